// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the UART-to-debug-module command bridge.
package dbg_bridge_pkg;

  // Bridge sequencer states, in the order a command frame moves through them.
  typedef enum logic [2:0] {
    RX_CMD,
    RX_ADDR,
    RX_DATA,
    ISSUE,
    WAIT,
    RELEASE,
    TX_STAT,
    TX_DATA
  } bridge_state_e;

  // Status byte values returned as the first byte of every response.
  localparam logic [7:0] STAT_ACK     = 8'hA5;
  localparam logic [7:0] STAT_ERR_CMD = 8'hE1;
  localparam logic [7:0] STAT_ERR_TMO = 8'hE2;

  // Idle value on the dbg_module command bus.
  localparam logic [7:0] CMD_NONE = 8'h00;

  // Frame geometry: 1 command byte + two 32-bit words in, 1 status byte + one word out.
  localparam int FRAME_BYTES = 9;
  localparam int RESP_BYTES  = 5;

  // Commands dbg_module understands; everything else is answered with ERR_CMD.
  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    logic ok;
    case (cmd)
      8'h00, 8'h01, 8'h02, 8'h05, 8'h06, 8'h07,
      8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbg_uart_bridge.sv
// Byte-stream front end for dbg_module: parses 9-byte command frames from a
// UART RX byte stream, runs the cmd/addr/data/ready handshake with dbg_module,
// and streams back a 5-byte status + result response on the UART TX side.
module dbg_uart_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 100000,
  parameter int CMD_TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        rx_drop_o
);

  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int CT_W = $clog2(CMD_TIMEOUT + 1);

  // The timeout fires on the cycle the counter would reach its limit.
  localparam logic [FT_W-1:0] FT_LAST = FT_W'(FRAME_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FT_MAX  = FT_W'(FRAME_TIMEOUT);
  localparam logic [CT_W-1:0] CT_LAST = CT_W'(CMD_TIMEOUT - 1);
  localparam logic [CT_W-1:0] CT_MAX  = CT_W'(CMD_TIMEOUT);

  // Index of the last byte of a 32-bit word in the frame and in the response.
  localparam logic [1:0] LAST_WORD_IDX = 2'(((FRAME_BYTES - 1) / 2) - 1);
  localparam logic [1:0] LAST_RESP_IDX = 2'(RESP_BYTES - 2);

  bridge_state_e   state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     result_q, result_d;
  logic [7:0]      status_q, status_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [FT_W-1:0] frame_tmr_q, frame_tmr_d;
  logic [CT_W-1:0] cmd_tmr_q, cmd_tmr_d;
  logic            rx_drop_q, rx_drop_d;

  // State and datapath registers; async reset returns everything to idle.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= RX_CMD;
      cmd_q       <= CMD_NONE;
      addr_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      status_q    <= '0;
      byte_cnt_q  <= '0;
      frame_tmr_q <= '0;
      cmd_tmr_q   <= '0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      result_q    <= result_d;
      status_q    <= status_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_tmr_q <= frame_tmr_d;
      cmd_tmr_q   <= cmd_tmr_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  // Next-state and datapath updates: frame parsing, command wait, response sequencing.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    result_d    = result_q;
    status_d    = status_q;
    byte_cnt_d  = byte_cnt_q;
    frame_tmr_d = frame_tmr_q;
    cmd_tmr_d   = cmd_tmr_q;
    rx_drop_d   = rx_valid_i && !(state_q inside {RX_CMD, RX_ADDR, RX_DATA});

    case (state_q)
      RX_CMD: begin
        frame_tmr_d = '0;
        cmd_tmr_d   = '0;
        if (rx_valid_i) begin
          cmd_d      = rx_data_i;
          addr_d     = '0;
          data_d     = '0;
          byte_cnt_d = '0;
          state_d    = RX_ADDR;
        end
      end

      RX_ADDR: begin
        if (rx_valid_i) begin
          addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
          frame_tmr_d = '0;
          if (byte_cnt_q == LAST_WORD_IDX) begin
            byte_cnt_d = '0;
            state_d    = RX_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (frame_tmr_q == FT_LAST) begin
          frame_tmr_d = '0;
          state_d     = RX_CMD;
        end else if (frame_tmr_q != FT_MAX) begin
          frame_tmr_d = frame_tmr_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (rx_valid_i) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
          frame_tmr_d = '0;
          if (byte_cnt_q == LAST_WORD_IDX) begin
            byte_cnt_d = '0;
            if (is_valid_cmd(cmd_q)) begin
              state_d = ISSUE;
            end else begin
              status_d = STAT_ERR_CMD;
              result_d = '0;
              state_d  = TX_STAT;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (frame_tmr_q == FT_LAST) begin
          frame_tmr_d = '0;
          state_d     = RX_CMD;
        end else if (frame_tmr_q != FT_MAX) begin
          frame_tmr_d = frame_tmr_q + 1'b1;
        end
      end

      ISSUE: begin
        cmd_tmr_d = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        if (dbg_ready_i) begin
          status_d = STAT_ACK;
          result_d = dbg_data_i;
          state_d  = RELEASE;
        end else if (cmd_tmr_q == CT_LAST) begin
          status_d = STAT_ERR_TMO;
          result_d = '0;
          state_d  = RELEASE;
        end else if (cmd_tmr_q != CT_MAX) begin
          cmd_tmr_d = cmd_tmr_q + 1'b1;
        end
      end

      RELEASE: begin
        state_d = TX_STAT;
      end

      TX_STAT: begin
        if (tx_ready_i) begin
          byte_cnt_d = '0;
          state_d    = TX_DATA;
        end
      end

      TX_DATA: begin
        if (tx_ready_i) begin
          if (byte_cnt_q == LAST_RESP_IDX) begin
            byte_cnt_d = '0;
            state_d    = RX_CMD;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = RX_CMD;
    endcase
  end

  // Output decode: the command bus is live only in ISSUE/WAIT so dbg_module never re-executes.
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    dbg_cmd_o  = CMD_NONE;
    dbg_addr_o = '0;
    dbg_data_o = '0;
    case (state_q)
      ISSUE, WAIT: begin
        dbg_cmd_o  = cmd_q;
        dbg_addr_o = addr_q;
        dbg_data_o = data_q;
      end
      TX_STAT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = status_q;
      end
      TX_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = result_q[{byte_cnt_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != RX_CMD);
  assign rx_drop_o = rx_drop_q;

endmodule

// File: doc/dbg_uart_bridge.md
Name: dbg_uart_bridge

Overview:
Byte-stream front end that feeds dbg_module. It takes fixed 9-byte command frames from a UART RX byte interface and drives dbg_module's cmd/addr/data/ready handshake. It then returns a fixed 5-byte response (status + 32-bit data) on a UART TX byte interface. It sits between the UART PHY and dbg_module, so a host PC can halt the core, resume it, peek and poke memory, and reset the core through a serial link.

Parameters:
FRAME_TIMEOUT, 100000, max idle cycles between bytes of one frame before the parser resyncs
CMD_TIMEOUT, 1000000, max cycles waiting for dbg_ready_i before the command is aborted

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous active-low reset
rx_data_i  in  8  received byte
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid; no backpressure
tx_data_o  out  8  byte to transmit
tx_valid_o  out  1  tx byte valid; held with data until tx_ready_i
tx_ready_i  in  1  UART TX accepts byte when tx_valid_o & tx_ready_i
dbg_cmd_o  out  8  command to dbg_module cmd_i
dbg_addr_o  out  32  to dbg_module addr_i
dbg_data_o  out  32  to dbg_module data_i
dbg_data_i  in  32  from dbg_module data_o
dbg_ready_i  in  1  from dbg_module ready_o (registered there, reset 1)
busy_o  out  1  high in any state other than RX_CMD
rx_drop_o  out  1  one-cycle pulse when an rx byte is discarded

Behaviour:
- Reset: state RX_CMD; all outputs 0; dbg_cmd_o=8'h00; internal addr/data/byte counter/timers cleared.
- Frame format: byte0=cmd; bytes1-4=addr, little-endian; bytes5-8=data, little-endian. All 9 bytes are always sent.
- Response format: byte0=status; bytes1-4=result data, little-endian.
- Status codes:
  - ACK 8'hA5 = success.
  - ERR_CMD 8'hE1 = unknown command; not issued; data 0.
  - ERR_TMO 8'hE2 = command timeout; data 0.
- Valid commands: 00, 01, 02, 05, 06, 07, 11, 12, 13, 14, 15, 16. Anything else is ERR_CMD.
- FSM states: RX_CMD, RX_ADDR, RX_DATA, ISSUE, WAIT, RELEASE, TX_STAT, TX_DATA.
- RX_CMD: latch cmd on rx_valid_i -> RX_ADDR; clear the byte counter.
- RX_ADDR: 4 bytes, byte k goes to addr[8k+7:8k] -> RX_DATA.
- RX_DATA: 4 bytes into data -> ISSUE if cmd valid, else TX_STAT with ERR_CMD.
- Inter-byte timer runs in RX_ADDR and RX_DATA:
  - reset on every rx_valid_i;
  - if it reaches FRAME_TIMEOUT: discard the partial frame, go to RX_CMD, send no response.
- ISSUE (exactly 1 cycle): drive dbg_cmd_o=cmd, dbg_addr_o=addr, dbg_data_o=data -> WAIT.
  - dbg_module's ready is registered, so dbg_ready_i must not be sampled in this cycle.
- WAIT: keep driving the cmd/addr/data outputs stable.
  - If dbg_ready_i=1: capture dbg_data_i as result (ACK) -> RELEASE.
  - Reset commands (05/06/07) and 00 complete with result = current dbg_data_i. Their request pulse lasts 2 cycles (ISSUE + first WAIT).
  - Command timer counts the cycles spent in WAIT. At CMD_TIMEOUT: status ERR_TMO, result 0 -> RELEASE.
- RELEASE (1 cycle): dbg_cmd_o=8'h00, addr/data outputs 0 -> TX_STAT.
  - dbg_cmd_o is 8'h00 in every state except ISSUE and WAIT. This guarantees dbg_module never re-executes a command.
- TX_STAT: tx_valid_o=1, tx_data_o=status; advance on handshake.
  - ERR_CMD path -> RX_CMD after status plus 4 data bytes of 0.
  - Otherwise -> TX_DATA.
- TX_DATA: 4 bytes of result, LSB first; after the 4th handshake -> RX_CMD.
- tx_valid_o must not drop and tx_data_o must not change until the handshake completes.
- rx_valid_i in any state ISSUE through TX_DATA: byte dropped, rx_drop_o pulses 1 cycle.
- Async reset mid-frame or mid-command: immediate return to the reset values; no response is sent.
- Timer widths are $clog2(param+1). Both timers saturate and never wrap.

Decomposition:
- Package dbg_bridge_pkg:
  - state enum;
  - status constants ACK / ERR_CMD / ERR_TMO;
  - frame length constants (FRAME_BYTES=9, RESP_BYTES=5);
  - valid-command check function.
- No sub-module needed. The timers are inline counters.

Test Plan:
1. Write frame 02, addr 0x00001000, data 0xDEADBEEF; dbg model drops ready for 5 cycles -> dbg_cmd_o=02 with stable addr/data for all 6 cycles; then cmd=00; response A5 EF BE AD DE.
2. Read frame 13, addr 0x05, data 0; model returns 0x12345678 with ready -> response A5 78 56 34 12; dbg_addr_o=0x5 throughout WAIT.
3. Frame 05 (core reset); model keeps ready=1 -> cmd=05 for exactly 2 cycles, then 00; response A5 + 4 bytes of dbg_data_i.
4. Frame with cmd 0x42 -> dbg_cmd_o never leaves 00; response E1 00 00 00 00.
5. Send 3 bytes, then idle FRAME_TIMEOUT cycles, then a full 11 (halt) frame -> no response to the partial frame; the halt frame executes and answers A5.
6. Model holds ready=0 forever on 01 -> response E2 00 00 00 00 after CMD_TIMEOUT; tx_ready_i toggled randomly during the response -> bytes held stable; rx byte injected during WAIT -> rx_drop_o pulse.
